// File: rtl/conv2d_pkg.sv
// Shared types and constants for the conv2d layer sequencer.
package conv2d_pkg;

  localparam int          KS_DEF    = 3;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Width of a packed KSxKS fp32 weight bus.
  function automatic int wt_bus_w(input int ks);
    return ks * ks * 32;
  endfunction

endpackage

// File: rtl/conv2d_pass_cnt.sv
// Per-pass pixel/output counters with expected-count compare.
module conv2d_pass_cnt
  import conv2d_pkg::*;
#(
  parameter int C_WIDTH = 9,
  parameter int KS      = KS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_ena_x,
  input  logic               i_ena_z,
  input  logic [C_WIDTH-1:0] i_width,
  input  logic [C_WIDTH-1:0] i_height,
  output logic               o_pix_full,
  output logic               o_z_mismatch
);

  localparam int                 CW2 = 2 * C_WIDTH;
  localparam logic [C_WIDTH-1:0] KM1 = C_WIDTH'(KS - 1);

  logic [CW2-1:0] r_pix_cnt;
  logic [CW2-1:0] r_z_cnt;
  logic [CW2-1:0] w_pix_total;
  logic [CW2-1:0] w_z_expect;
  logic [CW2-1:0] w_z_now;

  assign w_pix_total = CW2'(i_width) * CW2'(i_height);
  assign w_z_expect  = CW2'(i_width - KM1) * CW2'(i_height - KM1);
  // An output arriving together with the overflow flag still belongs to this pass.
  assign w_z_now     = r_z_cnt + CW2'(i_ena_z);

  assign o_pix_full   = (r_pix_cnt >= w_pix_total);
  assign o_z_mismatch = (w_z_now != w_z_expect);

  // Count accepted input pixels and produced outputs; cleared when a pass is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_cnt <= '0;
      r_z_cnt   <= '0;
    end else if (i_clr) begin
      r_pix_cnt <= '0;
      r_z_cnt   <= '0;
    end else begin
      if (i_ena_x) r_pix_cnt <= r_pix_cnt + CW2'(1);
      if (i_ena_z) r_z_cnt   <= r_z_cnt + CW2'(1);
    end
  end

endmodule

// File: rtl/conv2d_layer_ctrl.sv
// Layer sequencer for the 3x3 fp32 convolution core.
// Optional macro CONV2D_LAYER_CTRL_BIAS_EN: adds wt_bias, injected as the
// first-pass partial sum instead of zero.
module conv2d_layer_ctrl
  import conv2d_pkg::*;
#(
  parameter int C_WIDTH = 9,
  parameter int KS      = KS_DEF,
  parameter int CH_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [C_WIDTH-1:0]        cfg_width_in,
  input  logic [C_WIDTH-1:0]        cfg_height_in,
  input  logic [CH_W-1:0]           cfg_n_ic,
  input  logic [CH_W-1:0]           cfg_n_oc,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic                      wt_req,
  output logic [CH_W-1:0]           wt_oc,
  output logic [CH_W-1:0]           wt_ic,
  input  logic                      wt_vld,
  input  logic [wt_bus_w(KS)-1:0]   wt_data,
`ifdef CONV2D_LAYER_CTRL_BIAS_EN
  input  logic [31:0]               wt_bias,
`endif
  output logic                      src_start,
  output logic [CH_W-1:0]           src_ic,
  input  logic                      src_vld,
  input  logic [31:0]               src_data,
  output logic                      src_rdy,
  output logic                      param_ena,
  output logic [wt_bus_w(KS)-1:0]   param_weight,
  output logic [C_WIDTH-1:0]        param_width_in,
  output logic [C_WIDTH-1:0]        param_height_out,
  output logic                      pxl_ena_x,
  output logic [31:0]               pxl_x,
  input  logic                      pxl_ena_y,
  output logic [31:0]               pxl_y,
  input  logic                      pxl_ena_z,
  input  logic [31:0]               pxl_z,
  input  logic                      pxl_ovr,
  input  logic                      psum_empty,
  input  logic [31:0]               psum_q,
  output logic                      psum_rd,
  output logic                      psum_wr,
  output logic [31:0]               psum_wdata,
  output logic                      out_vld,
  output logic [31:0]               out_data,
  output logic [CH_W-1:0]           out_oc
);

  localparam logic [C_WIDTH-1:0] KS_C = C_WIDTH'(KS);
  localparam logic [C_WIDTH-1:0] KM1  = C_WIDTH'(KS - 1);

  state_e                  r_state;
  logic [C_WIDTH-1:0]      r_width;
  logic [C_WIDTH-1:0]      r_height;
  logic [CH_W-1:0]         r_n_ic;
  logic [CH_W-1:0]         r_n_oc;
  logic [CH_W-1:0]         r_oc;
  logic [CH_W-1:0]         r_ic;
  logic                    r_err;
  logic                    r_stream_first;
  logic [wt_bus_w(KS)-1:0] r_wt;
  logic [C_WIDTH-1:0]      r_param_w;
  logic [C_WIDTH-1:0]      r_param_h;
  logic [31:0]             w_first_y;

  logic w_first;
  logic w_last;
  logic w_pix_full;
  logic w_z_mismatch;
  logic w_cfg_bad;
  logic w_cfg_empty;

`ifdef CONV2D_LAYER_CTRL_BIAS_EN
  logic [31:0] r_bias;
  assign w_first_y = r_bias;
`else
  assign w_first_y = FP32_ZERO;
`endif

  assign w_first     = (r_ic == '0);
  assign w_last      = (r_ic == r_n_ic - CH_W'(1));
  assign w_cfg_bad   = (cfg_width_in < KS_C) || (cfg_height_in < KS_C);
  assign w_cfg_empty = (cfg_n_ic == '0) || (cfg_n_oc == '0);

  conv2d_pass_cnt #(
    .C_WIDTH (C_WIDTH),
    .KS      (KS)
  ) u_pass_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (r_state == ST_LOAD),
    .i_ena_x      (pxl_ena_x),
    .i_ena_z      (pxl_ena_z),
    .i_width      (r_width),
    .i_height     (r_height),
    .o_pix_full   (w_pix_full),
    .o_z_mismatch (w_z_mismatch)
  );

  assign cfg_busy         = (r_state != ST_IDLE);
  assign cfg_done         = (r_state == ST_DONE);
  assign cfg_err          = r_err;
  assign wt_req           = (r_state == ST_FETCH);
  assign wt_oc            = r_oc;
  assign wt_ic            = r_ic;
  assign src_start        = r_stream_first;
  assign src_ic           = r_ic;
  assign param_ena        = (r_state == ST_LOAD);
  assign param_weight     = r_wt;
  assign param_width_in   = r_param_w;
  assign param_height_out = r_param_h;

  // The cycle after src_start is the earliest accept, giving the core two
  // cycles after param_ena; an overflow aborts acceptance immediately.
  assign src_rdy   = (r_state == ST_STREAM) && !r_stream_first && !w_pix_full && !pxl_ovr;
  assign pxl_ena_x = src_vld && src_rdy;
  assign pxl_x     = src_data;

  assign pxl_y      = w_first ? w_first_y : psum_q;
  assign psum_rd    = pxl_ena_y && !w_first;
  assign psum_wr    = pxl_ena_z && !w_last;
  assign psum_wdata = pxl_z;
  assign out_vld    = pxl_ena_z && w_last;
  assign out_data   = pxl_z;
  assign out_oc     = r_oc;

  // Layer sequencing: fetch, load, stream and drain each (oc, ic) pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_width        <= '0;
      r_height       <= '0;
      r_n_ic         <= '0;
      r_n_oc         <= '0;
      r_oc           <= '0;
      r_ic           <= '0;
      r_err          <= 1'b0;
      r_stream_first <= 1'b0;
      r_wt           <= '0;
      r_param_w      <= '0;
      r_param_h      <= '0;
`ifdef CONV2D_LAYER_CTRL_BIAS_EN
      r_bias         <= '0;
`endif
    end else begin
      r_stream_first <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_width  <= cfg_width_in;
            r_height <= cfg_height_in;
            r_n_ic   <= cfg_n_ic;
            r_n_oc   <= cfg_n_oc;
            r_oc     <= '0;
            r_ic     <= '0;
            r_err    <= w_cfg_bad;
            r_state  <= (w_cfg_bad || w_cfg_empty) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (wt_vld) begin
            r_wt      <= wt_data;
`ifdef CONV2D_LAYER_CTRL_BIAS_EN
            r_bias    <= wt_bias;
`endif
            r_param_w <= r_width;
            r_param_h <= r_height - KM1;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_stream_first <= 1'b1;
          r_state        <= ST_STREAM;
        end
        ST_STREAM: begin
          if (pxl_ovr) begin
            r_err   <= 1'b1;
            r_state <= ST_NEXT;
          end else if (w_pix_full) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pxl_ovr) begin
            if (w_z_mismatch) r_err <= 1'b1;
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (r_ic + CH_W'(1) == r_n_ic) begin
            r_ic    <= '0;
            r_oc    <= r_oc + CH_W'(1);
            r_state <= (r_oc + CH_W'(1) == r_n_oc) ? ST_DONE : ST_FETCH;
          end else begin
            r_ic    <= r_ic + CH_W'(1);
            r_state <= ST_FETCH;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (psum_rd && psum_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv2d_layer_ctrl.sv
// Self-checking bench for conv2d_layer_ctrl with a weight store, pixel
// source, core stub and show-ahead partial-sum FIFO modelled in the bench.
`timescale 1ns/1ps
module tb_conv2d_layer_ctrl;
  import conv2d_pkg::*;

  localparam int C_WIDTH = 9;
  localparam int KS      = 3;
  localparam int CH_W    = 8;
  localparam int WT_W    = KS * KS * 32;
`ifdef CONV2D_LAYER_CTRL_BIAS_EN
  localparam logic [31:0] BIAS = 32'h3F80_0000;
  logic [31:0] wt_bias;
`else
  localparam logic [31:0] BIAS = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               cfg_start = 1'b0;
  logic [C_WIDTH-1:0] cfg_width_in = '0, cfg_height_in = '0;
  logic [CH_W-1:0]    cfg_n_ic = '0, cfg_n_oc = '0;
  logic               cfg_busy, cfg_done, cfg_err;
  logic               wt_req, wt_vld;
  logic [CH_W-1:0]    wt_oc, wt_ic, src_ic, out_oc;
  logic [WT_W-1:0]    wt_data, param_weight;
  logic               src_start, src_vld, src_rdy;
  logic [31:0]        src_data, pxl_x, pxl_y, pxl_z, psum_q, psum_wdata, out_data;
  logic               param_ena;
  logic [C_WIDTH-1:0] param_width_in, param_height_out;
  logic               pxl_ena_x, pxl_ena_y, pxl_ena_z, pxl_ovr;
  logic               psum_empty, psum_rd, psum_wr, out_vld;

  conv2d_layer_ctrl #(.C_WIDTH(C_WIDTH), .KS(KS), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_width_in(cfg_width_in), .cfg_height_in(cfg_height_in),
    .cfg_n_ic(cfg_n_ic), .cfg_n_oc(cfg_n_oc),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .wt_req(wt_req), .wt_oc(wt_oc), .wt_ic(wt_ic), .wt_vld(wt_vld), .wt_data(wt_data),
`ifdef CONV2D_LAYER_CTRL_BIAS_EN
    .wt_bias(wt_bias),
`endif
    .src_start(src_start), .src_ic(src_ic), .src_vld(src_vld), .src_data(src_data),
    .src_rdy(src_rdy),
    .param_ena(param_ena), .param_weight(param_weight),
    .param_width_in(param_width_in), .param_height_out(param_height_out),
    .pxl_ena_x(pxl_ena_x), .pxl_x(pxl_x), .pxl_ena_y(pxl_ena_y), .pxl_y(pxl_y),
    .pxl_ena_z(pxl_ena_z), .pxl_z(pxl_z), .pxl_ovr(pxl_ovr),
    .psum_empty(psum_empty), .psum_q(psum_q), .psum_rd(psum_rd),
    .psum_wr(psum_wr), .psum_wdata(psum_wdata),
    .out_vld(out_vld), .out_data(out_data), .out_oc(out_oc)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] tagf(input int oc, input int ic);
    return 32'(oc * 16 + ic + 1);
  endfunction

  function automatic logic [WT_W-1:0] make_wt(input int oc, input int ic);
    logic [WT_W-1:0] w;
    logic [31:0]     t;
    t = tagf(oc, ic);
    w = '0;
    for (int i = 0; i < KS * KS; i++)
      w[i*32 +: 32] = (i == 0) ? t : ((t * 32'(i + 1)) ^ 32'hC0DE_0000);
    return w;
  endfunction

  // Environment state
  bit          want_rst = 1'b1;
  int          wt_wait = 0;
  bit          src_active = 0, src_rand = 0;
  int          src_idx = 0;
  logic [31:0] tag = '0;
  int          total_px = 0, nz = 0, acc = 0, ky = 0, abort_at = 0;
  bit          emitting = 0, ovr_pend = 0, ovr_is_abort = 0;
  logic [31:0] zq[$];
  logic [31:0] fifo[$];
  int          fetch_oc[$], fetch_ic[$];
  int          cur_oc = 0, cur_ic = 0;

  // Model / scoreboard state
  logic [31:0] exp_q[$];
  int          exp_oc_q[$];
  int          exp_w = 0, exp_h = 0;
  int          n_param, n_x, n_out, n_out_oc0, n_pwr, n_prd, n_done, n_wtreq;
  int          cyc = 0, pe_cyc = 0, done_cyc = 0, start_cyc = 0;
  bit          err_at_done, got_first;
  logic [31:0] first_out, last_out;

  // Environment: drive inputs on the falling edge, react to DUT outputs after.
  initial begin : env
    forever begin
      @(negedge clk);
      rst = !want_rst;
      if (want_rst) begin
        emitting = 0; ovr_pend = 0; ovr_is_abort = 0; src_active = 0;
        wt_wait = 0; ky = 0; acc = 0; nz = 0; abort_at = 0;
        zq.delete(); fifo.delete();
      end
      wt_vld     = wt_req && (wt_wait >= 2);
      wt_data    = wt_req ? make_wt(int'(wt_oc), int'(wt_ic)) : '0;
`ifdef CONV2D_LAYER_CTRL_BIAS_EN
      wt_bias    = wt_req ? BIAS : 32'h0;
`endif
      src_vld    = src_active && (acc < total_px) && (!src_rand || $urandom_range(0, 1) == 1);
      src_data   = src_active ? (32'hA000_0000 + 32'(src_idx)) : 32'h0;
      pxl_ena_y  = emitting && (ky < nz);
      pxl_ena_z  = (zq.size() > 0);
      pxl_z      = (zq.size() > 0) ? zq[0] : 32'h0;
      pxl_ovr    = ovr_pend;
      psum_empty = (fifo.size() == 0);
      psum_q     = (fifo.size() > 0) ? fifo[0] : 32'h0;
      #2;
      if (want_rst) continue;
      if (wt_req) begin
        if (wt_vld) begin
          wt_wait = 0;
          cur_oc = int'(wt_oc); cur_ic = int'(wt_ic);
          fetch_oc.push_back(cur_oc); fetch_ic.push_back(cur_ic);
        end else wt_wait++;
      end
      if (ovr_pend) begin
        ovr_pend = 0; ovr_is_abort = 0; emitting = 0; src_active = 0;
      end
      if (param_ena) begin
        tag      = param_weight[31:0];
        total_px = int'(param_width_in) * (int'(param_height_out) + 2);
        nz       = (int'(param_width_in) - 2) * int'(param_height_out);
        acc = 0; ky = 0; emitting = 0; src_active = 0;
      end
      if (src_start) begin src_active = 1; src_idx = 0; end
      if (pxl_ena_x) begin
        src_idx++; acc++;
        if (acc == total_px) emitting = 1;
        if (abort_at > 0 && acc == abort_at) begin
          ovr_pend = 1; ovr_is_abort = 1; abort_at = 0;
        end
      end
      if (pxl_ena_z) void'(zq.pop_front());
      if (pxl_ena_y) begin zq.push_back(pxl_y + tag + 32'(ky)); ky++; end
      if (emitting && ky == nz && zq.size() == 0 && !ovr_pend) begin
        ovr_pend = 1; emitting = 0;
      end
      if (psum_rd && fifo.size() > 0) void'(fifo.pop_front());
      if (psum_wr) fifo.push_back(psum_wdata);
    end
  end

  // Compare process: checks DUT outputs against the model every cycle.
  initial begin : cmp
    logic [31:0] ey;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (param_ena) begin
        n_param++; pe_cyc = cyc;
        check("param_weight", 64'(param_weight == make_wt(cur_oc, cur_ic)), 64'd1);
        check("param_width_in", 64'(param_width_in), 64'(exp_w));
        check("param_height_out", 64'(param_height_out), 64'(exp_h - 2));
      end
      if (pxl_ena_x) begin
        n_x++;
        check("pxl_x", 64'(pxl_x), 64'(32'hA000_0000 + 32'(src_idx)));
        check("px_after_param_plus2", 64'(cyc - pe_cyc >= 2), 64'd1);
      end
      if (pxl_ovr && ovr_is_abort) check("src_rdy_on_abort", 64'(src_rdy), 64'd0);
      if (pxl_ena_y) begin
        ey = (cur_ic == 0) ? BIAS : ((fifo.size() > 0) ? fifo[0] : 32'h0);
        check("pxl_y", 64'(pxl_y), 64'(ey));
      end
      if (psum_rd) begin
        n_prd++;
        check("psum_rd_nonempty", 64'(psum_empty), 64'd0);
      end
      if (psum_wr) begin
        n_pwr++;
        check("psum_wdata", 64'(psum_wdata), 64'(pxl_z));
      end
      if (out_vld) begin
        n_out++;
        if (out_oc == 0) n_out_oc0++;
        if (!got_first) begin first_out = out_data; got_first = 1; end
        last_out = out_data;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_extra: got %0h, expected no output", out_data);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
          check("out_oc", 64'(out_oc), 64'(exp_oc_q.pop_front()));
        end
      end
      if (wt_req) n_wtreq++;
      if (cfg_done) begin n_done++; done_cyc = cyc; err_at_done = cfg_err; end
    end
  end

  task automatic prep_layer(input int w, input int h, input int nic, input int noc,
                            input bit rnd, input int abort_px, input int skip_oc);
    logic [31:0] v;
    int nzl;
    exp_w = w; exp_h = h; src_rand = rnd; abort_at = abort_px;
    n_param = 0; n_x = 0; n_out = 0; n_out_oc0 = 0; n_pwr = 0; n_prd = 0;
    n_done = 0; n_wtreq = 0; got_first = 0; err_at_done = 0;
    exp_q.delete(); exp_oc_q.delete(); fetch_oc.delete(); fetch_ic.delete();
    nzl = (w - 2) * (h - 2);
    if (w >= 3 && h >= 3)
      for (int oc = skip_oc; oc < noc; oc++)
        for (int k = 0; k < nzl; k++) begin
          v = BIAS;
          for (int ic = 0; ic < nic; ic++) v = v + tagf(oc, ic) + 32'(k);
          exp_q.push_back(v); exp_oc_q.push_back(oc);
        end
    @(negedge clk); #3;
    cfg_width_in = C_WIDTH'(w); cfg_height_in = C_WIDTH'(h);
    cfg_n_ic = CH_W'(nic); cfg_n_oc = CH_W'(noc);
    cfg_start = 1'b1; start_cyc = cyc;
    @(negedge clk); #3;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (n_done == 0 && t < 4000) begin @(negedge clk); t++; end
    if (n_done == 0) begin
      checks++; errors++;
      $display("FAIL layer_timeout: got no cfg_done, expected one within 4000 cycles");
    end
    repeat (3) @(negedge clk);
    #3;
  endtask

  task automatic check_fetches(input int n, input int oc_l[4], input int ic_l[4]);
    check("fetch_count", 64'(fetch_oc.size()), 64'(n));
    for (int i = 0; i < n && i < fetch_oc.size(); i++) begin
      check("fetch_oc", 64'(fetch_oc[i]), 64'(oc_l[i]));
      check("fetch_ic", 64'(fetch_ic[i]), 64'(ic_l[i]));
    end
  endtask

  function automatic logic any_out();
    return cfg_busy | cfg_done | cfg_err | wt_req | (|wt_oc) | (|wt_ic) | src_start |
           (|src_ic) | src_rdy | param_ena | (|param_weight) | (|param_width_in) |
           (|param_height_out) | pxl_ena_x | (|pxl_x) | (|pxl_y) | psum_rd | psum_wr |
           (|psum_wdata) | out_vld | (|out_data) | (|out_oc);
  endfunction

  initial begin : main
    int t;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_zero", 64'(any_out()), 64'd0);
    #2; want_rst = 1'b0;
    repeat (2) @(negedge clk);

    // 5x5, one channel each way
    prep_layer(5, 5, 1, 1, 0, 0, 0);
    wait_done();
    check("t1_param_ena", 64'(n_param), 64'd1);
    check("t1_pxl_ena_x", 64'(n_x), 64'd25);
    check("t1_out_vld", 64'(n_out), 64'd9);
    check("t1_psum_wr", 64'(n_pwr), 64'd0);
    check("t1_psum_rd", 64'(n_prd), 64'd0);
    check("t1_done", 64'(n_done), 64'd1);
    check("t1_err", 64'(err_at_done), 64'd0);
    check("t1_first_out", 64'(first_out), 64'(BIAS + 32'd1));
    check("t1_last_out", 64'(last_out), 64'(BIAS + 32'd9));
    check("t1_all_out", 64'(exp_q.size()), 64'd0);

    // 6x5, two input and two output channels with partial-sum chaining
    prep_layer(6, 5, 2, 2, 0, 0, 0);
    wait_done();
    check_fetches(4, '{0, 0, 1, 1}, '{0, 1, 0, 1});
    check("t2_param_ena", 64'(n_param), 64'd4);
    check("t2_pxl_ena_x", 64'(n_x), 64'd120);
    check("t2_psum_wr", 64'(n_pwr), 64'd24);
    check("t2_psum_rd", 64'(n_prd), 64'd24);
    check("t2_out_vld", 64'(n_out), 64'd24);
    check("t2_out_oc0", 64'(n_out_oc0), 64'd12);
    check("t2_first_out", 64'(first_out), 64'(BIAS + 32'd3));
    check("t2_err", 64'(err_at_done), 64'd0);
    check("t2_all_out", 64'(exp_q.size()), 64'd0);

    // Random source gaps
    prep_layer(5, 5, 1, 1, 1, 0, 0);
    wait_done();
    check("t3_pxl_ena_x", 64'(n_x), 64'd25);
    check("t3_out_vld", 64'(n_out), 64'd9);
    check("t3_err", 64'(err_at_done), 64'd0);
    check("t3_all_out", 64'(exp_q.size()), 64'd0);

    // Premature overflow during the first pass
    prep_layer(5, 5, 1, 2, 0, 10, 1);
    wait_done();
    check_fetches(2, '{0, 1, 0, 0}, '{0, 0, 0, 0});
    check("t4_err", 64'(err_at_done), 64'd1);
    check("t4_done", 64'(n_done), 64'd1);
    check("t4_pxl_ena_x", 64'(n_x), 64'd35);
    check("t4_out_vld", 64'(n_out), 64'd9);
    check("t4_out_oc0", 64'(n_out_oc0), 64'd0);
    check("t4_first_out", 64'(first_out), 64'(BIAS + 32'd17));

    // Plane narrower than the kernel
    prep_layer(2, 5, 1, 1, 0, 0, 0);
    wait_done();
    check("t5_done_latency", 64'(done_cyc - start_cyc <= 3), 64'd1);
    check("t5_err", 64'(err_at_done), 64'd1);
    check("t5_wt_req", 64'(n_wtreq), 64'd0);

    // Zero output channels
    prep_layer(5, 5, 1, 0, 0, 0, 0);
    wait_done();
    check("t6_done", 64'(n_done), 64'd1);
    check("t6_err", 64'(err_at_done), 64'd0);
    check("t6_wt_req", 64'(n_wtreq), 64'd0);
    check("t6_err_flag_cleared", 64'(cfg_err), 64'd0);

    // Reset while draining, then a fresh layer
    prep_layer(5, 5, 1, 1, 0, 0, 0);
    t = 0;
    while (ky < 3 && t < 500) begin @(negedge clk); t++; end
    #3;
    check("t7_busy_before_rst", 64'(cfg_busy), 64'd1);
    want_rst = 1'b1;
    @(negedge clk); #1;
    check("t7_outputs_zero_in_rst", 64'(any_out()), 64'd0);
    #2; want_rst = 1'b0;
    repeat (2) @(negedge clk);
    prep_layer(5, 5, 1, 1, 0, 0, 0);
    wait_done();
    check("t7_done", 64'(n_done), 64'd1);
    check("t7_out_vld", 64'(n_out), 64'd9);
    check("t7_err", 64'(err_at_done), 64'd0);
    check("t7_first_out", 64'(first_out), 64'(BIAS + 32'd1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
